memory_read_responder: RTL and testbench

Serving end of the `memory_read_iface` protocol: accepts the single arbitrated instruction-fetch request stream that the topology's round-robin memory arbiter drives (`addr`/`valid` in, `ready`/`data` out) and answers each request from an on-chip instruction RAM. A host-side write port loads the regex program. A one-entry last-address hit register shortens repeated fetches, which the arbiter produces often when several engines fetch the same PC. It sits between the topology's arbitrated memory port and the program store.

---
 rtl/memory_read_responder_pkg.sv | 17 +
 rtl/memory_read_responder_if.sv | 21 ++
 rtl/memory_read_responder_bram.sv | 33 +++
 rtl/memory_read_responder.sv | 150 +++++++++++++++
 tb/tb_memory_read_responder.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/memory_read_responder_pkg.sv
// memory_responder_pkg: shared FSM encoding and limits for the memory read responder.
// Revision 1.0 - initial release.
`default_nettype none

package memory_responder_pkg;

  localparam int MAX_READ_LATENCY = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } memory_responder_state_t;

endpackage

`default_nettype wire

// File: rtl/memory_read_responder_if.sv
// memory_read_iface: arbitrated fetch request/response bundle (addr/valid in, ready/data out).
// Revision 1.0 - initial release.
`default_nettype none

interface memory_read_iface #(
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11
);

  logic [MEMORY_ADDR_WIDTH-1:0] addr;
  logic                         valid;
  logic                         ready;
  logic [MEMORY_WIDTH-1:0]      data;

  // Requester side (arbiter) and serving side (responder).
  modport out (output addr, output valid, input  ready, input  data);
  modport in  (input  addr, input  valid, output ready, output data);

endinterface

`default_nettype wire

// File: rtl/memory_read_responder_bram.sv
// bram_sdp_pipelined: simple dual-port inferred RAM, read-first, READ_LATENCY output stages.
// Revision 1.0 - initial release.
`default_nettype none

module bram_sdp_pipelined #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 11,
  parameter int READ_LATENCY = 1
) (
  input  wire logic                  clk,
  input  wire logic                  wr_en,
  input  wire logic [ADDR_WIDTH-1:0] wr_addr,
  input  wire logic [DATA_WIDTH-1:0] wr_data,
  input  wire logic                  rd_en,
  input  wire logic [ADDR_WIDTH-1:0] rd_addr,
  output logic      [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q  [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] pipe_q [READ_LATENCY];

  // No reset on the array or pipe so the storage maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) pipe_q[0] <= mem_q[rd_addr];
    for (int i = 1; i < READ_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
  end

  assign rd_data = pipe_q[READ_LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/memory_read_responder.sv
// memory_read_responder: serves arbitrated fetch requests from program RAM with a last-address hit register.
// Revision 1.0 - initial release.
`default_nettype none

module memory_read_responder
  import memory_responder_pkg::*;
#(
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11,
  parameter int READ_LATENCY      = 1
) (
  input  wire logic                         clk,
  input  wire logic                         rst,
  memory_read_iface.in                      memory,
  input  wire logic                         wr_en,
  input  wire logic [MEMORY_ADDR_WIDTH-1:0] wr_addr,
  input  wire logic [MEMORY_WIDTH-1:0]      wr_data,
  output logic                              busy
);

  generate
    if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
      $error("memory_read_responder: READ_LATENCY out of range 1..%0d", MAX_READ_LATENCY);
    end
  endgenerate

  memory_responder_state_t      state_q, state_d;
  logic [2:0]                   cnt_q, cnt_d;
  logic [MEMORY_ADDR_WIDTH-1:0] cap_addr_q, cap_addr_d;
  logic [MEMORY_ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic                         hit_valid_q, hit_valid_d;
  logic                         fwd_valid_q, fwd_valid_d;
  logic [MEMORY_WIDTH-1:0]      fwd_data_q, fwd_data_d;
  logic [MEMORY_WIDTH-1:0]      data_q, data_d;
  logic                         ready_q, ready_d;
  logic                         busy_q, busy_d;

  logic                         rd_en;
  logic [MEMORY_WIDTH-1:0]      rd_data;
  logic                         wr_last;
  logic                         wr_cap;

  bram_sdp_pipelined #(
    .DATA_WIDTH  (MEMORY_WIDTH),
    .ADDR_WIDTH  (MEMORY_ADDR_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_en  (rd_en),
    .rd_addr(memory.addr),
    .rd_data(rd_data)
  );

  assign wr_last = wr_en && (wr_addr == last_addr_q);
  assign wr_cap  = wr_en && (wr_addr == cap_addr_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap_addr_d  = cap_addr_q;
    last_addr_d = last_addr_q;
    hit_valid_d = hit_valid_q;
    fwd_valid_d = fwd_valid_q;
    fwd_data_d  = fwd_data_q;
    data_d      = data_q;
    rd_en       = 1'b0;

    // Any write to the cached address invalidates it; the next fetch re-reads RAM.
    if (wr_last) hit_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (memory.valid) begin
          if (hit_valid_q && memory.addr == last_addr_q && !wr_last) begin
            state_d = RESP;
          end else begin
            // A write landing in the launch cycle is missed by the read-first RAM, so forward it.
            cap_addr_d  = memory.addr;
            rd_en       = 1'b1;
            cnt_d       = 3'(READ_LATENCY);
            fwd_valid_d = wr_en && (wr_addr == memory.addr);
            fwd_data_d  = wr_data;
            state_d     = READ;
          end
        end
      end
      READ: begin
        if (!memory.valid) begin
          state_d     = IDLE;
          cnt_d       = 3'd0;
          fwd_valid_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 3'd1;
          if (wr_cap) begin
            fwd_valid_d = 1'b1;
            fwd_data_d  = wr_data;
          end
          if (cnt_q == 3'd1) begin
            data_d      = wr_cap ? wr_data : (fwd_valid_q ? fwd_data_q : rd_data);
            last_addr_d = cap_addr_q;
            hit_valid_d = 1'b1;
            fwd_valid_d = 1'b0;
            state_d     = RESP;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == RESP);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      cap_addr_q  <= '0;
      last_addr_q <= '0;
      hit_valid_q <= 1'b0;
      fwd_valid_q <= 1'b0;
      fwd_data_q  <= '0;
      data_q      <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cap_addr_q  <= cap_addr_d;
      last_addr_q <= last_addr_d;
      hit_valid_q <= hit_valid_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_data_q  <= fwd_data_d;
      data_q      <= data_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign memory.ready = ready_q;
  assign memory.data  = data_q;
  assign busy         = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_memory_read_responder.sv
// tb_memory_read_responder: scoreboard bench for memory_read_responder with READ_LATENCY=2.
// Revision 1.0 - initial release.
`default_nettype none

module tb_memory_read_responder;

  localparam int MW  = 16;
  localparam int AW  = 11;
  localparam int LAT = 2;
  localparam int MISS = 1 + LAT;
  localparam int HIT  = 1;

  typedef struct {
    logic [MW-1:0] data;
    int            start;
    int            lat;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [MW-1:0] wr_data;
  logic          busy;
  int            cyc;
  int            n_tests;
  int            n_fail;
  exp_t          sb_q[$];

  memory_read_iface #(.MEMORY_WIDTH(MW), .MEMORY_ADDR_WIDTH(AW)) mem_if ();

  memory_read_responder #(
    .MEMORY_WIDTH     (MW),
    .MEMORY_ADDR_WIDTH(AW),
    .READ_LATENCY     (LAT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .memory (mem_if),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Response monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (mem_if.ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("spurious_ready", 32'(mem_if.ready), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("resp_data", 32'(mem_if.data), 32'(e.data));
        check("resp_latency", 32'(cyc - e.start), 32'(e.lat));
      end
    end
  end

  task automatic wr(input logic [AW-1:0] a, input logic [MW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk); #1;
    wr_en   = 1'b0;
  endtask

  // Issue one request; optionally write wd to the same address wr_off cycles after launch.
  task automatic do_req(input logic [AW-1:0] a, input logic [MW-1:0] exp_d, input int lat,
                        input int wr_off, input logic [MW-1:0] wd);
    int busy_n = 0;
    bit done   = 1'b0;
    mem_if.addr  = a;
    mem_if.valid = 1'b1;
    sb_q.push_back('{exp_d, cyc, lat});
    for (int k = 0; k < 20 && !done; k++) begin
      if (wr_off != 0 && k == wr_off) begin
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = wd;
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
      if (busy) busy_n++;
      if (mem_if.ready) done = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    mem_if.valid = 1'b0;
    wr_en        = 1'b0;
    check("ready_seen", 32'(done), 32'd1);
    check("busy_cycles", 32'(busy_n), 32'(lat));
    @(posedge clk); #1;
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    cyc          = 0;
    rst          = 1'b1;
    wr_en        = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    mem_if.addr  = '0;
    mem_if.valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 32'(mem_if.ready), 32'd0);
    check("reset_data", 32'(mem_if.data), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Miss, then immediate hit on the same address.
    wr(11'h00A, 16'h1234);
    do_req(11'h00A, 16'h1234, MISS, 0, '0);
    do_req(11'h00A, 16'h1234, HIT, 0, '0);

    // Write to the captured address while the read is in flight is forwarded.
    do_req(11'h010, 16'hBEEF, MISS, 1, 16'hBEEF);

    // Write to the cached address invalidates the hit register.
    do_req(11'h00A, 16'h1234, MISS, 0, '0);
    do_req(11'h00A, 16'h1234, HIT, 0, '0);
    wr(11'h00A, 16'h5555);
    do_req(11'h00A, 16'h5555, MISS, 0, '0);

    // Address range boundaries.
    wr(11'h7FF, 16'hFFFF);
    wr(11'h000, 16'h0001);
    do_req(11'h7FF, 16'hFFFF, MISS, 0, '0);
    do_req(11'h000, 16'h0001, MISS, 0, '0);
    do_req(11'h000, 16'h0001, HIT, 0, '0);
    do_req(11'h010, 16'hBEEF, MISS, 0, '0);

    // Abort by dropping valid in the second READ cycle: no ready may follow.
    mem_if.addr  = 11'h7FF;
    mem_if.valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_if.valid = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    do_req(11'h7FF, 16'hFFFF, MISS, 0, '0);

    // Reset in the middle of a read.
    mem_if.addr  = 11'h123;
    mem_if.valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_ready", 32'(mem_if.ready), 32'd0);
    check("midrst_data", 32'(mem_if.data), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst          = 1'b0;
    mem_if.valid = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    do_req(11'h7FF, 16'hFFFF, MISS, 0, '0);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
